// File: rtl/contra_main_bus.sv
// Contra main-CPU bus glue: address decode, read mux, ROM banking,
// input ports, sound latch/IRQ and the video IRQ flip-flop.
module contra_main_bus (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_cen,
  input  logic [15:0] A,
  input  logic        RnW,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        irq_ack,
  output logic        irq_n,
  output logic        ram_cs,
  output logic        rom_cs,
  input  logic [7:0]  ram_dout,
  output logic [16:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic [12:0] cpu_addr,
  output logic        cpu_rnw,
  input  logic        gfx_irqn,
  output logic        gfx1_cs,
  output logic        gfx2_cs,
  output logic        gfx1_cfg_cs,
  output logic        gfx2_cfg_cs,
  output logic        pal_cs,
  input  logic [7:0]  gfx1_dout,
  input  logic [7:0]  gfx2_dout,
  input  logic [7:0]  pal_dout,
  output logic        snd_irq,
  output logic [7:0]  snd_latch,
  input  logic [1:0]  start_button,
  input  logic [1:0]  coin_input,
  input  logic [5:0]  joystick1,
  input  logic [5:0]  joystick2,
  input  logic        service,
  input  logic [7:0]  dipsw_a,
  input  logic [7:0]  dipsw_b,
  input  logic [3:0]  dipsw_c
);

  localparam int unsigned BANK_W = 4;
  localparam int unsigned DATA_W = 8;

  logic              bank_cs, in_cs, out_cs, io_page;
  logic [BANK_W-1:0] bank_q, bank_d, bank_page;
  logic              snd_irq_q, snd_irq_d;
  logic [DATA_W-1:0] snd_latch_q, snd_latch_d;
  logic [DATA_W-1:0] port_in_q, port_in_d;
  logic              irq_q, irq_d;
  logic              vrq_prev_q;

  // Address decode: all selects are purely combinational from A/RnW
  always_comb begin
    io_page     = (A[15:10] == 6'b000000);
    rom_cs      = (A[15] | (A[15:13] == 3'b011)) & RnW;
    bank_cs     = (A[15:12] == 4'b0111) & ~RnW;
    gfx1_cs     = (A[15:13] == 3'b001);
    gfx2_cs     = (A[15:13] == 3'b010);
    ram_cs      = (A[15:12] == 4'b0001);
    pal_cs      = (A[15:10] == 6'b000011);
    gfx1_cfg_cs = io_page & (A[7:5] == 3'b000) & ~RnW;
    gfx2_cfg_cs = io_page & (A[7:5] == 3'b011) & ~RnW;
    in_cs       = io_page & RnW;
    out_cs      = io_page & (A[4:3] == 2'b11) & ~RnW;
  end

  // Read data mux, first match wins, open bus reads as 0xFF
  always_comb begin
    cpu_din = 8'hFF;
    if      (rom_cs)  cpu_din = rom_data;
    else if (ram_cs)  cpu_din = ram_dout;
    else if (pal_cs)  cpu_din = pal_dout;
    else if (in_cs)   cpu_din = port_in_q;
    else if (gfx1_cs) cpu_din = gfx1_dout;
    else if (gfx2_cs) cpu_din = gfx2_dout;
  end

  // ROM address: fixed upper 32K, banked 8K window offset by 4 (wraps at 16)
  always_comb begin
    bank_page = BANK_W'(bank_q + 4'd4);
    if (A[15]) rom_addr = {2'b00, A[14:0]};
    else       rom_addr = {bank_page, A[12:0]};
  end

  // Next-state for CPU-written registers, input port and IRQ flop
  always_comb begin
    bank_d      = bank_q;
    snd_irq_d   = snd_irq_q;
    snd_latch_d = snd_latch_q;
    port_in_d   = port_in_q;
    irq_d       = irq_q;

    if (cpu_cen) begin
      snd_irq_d = 1'b0;
      if (bank_cs) bank_d = cpu_dout[3:0];
      if (out_cs) begin
        case (A[2:1])
          2'b01:   snd_irq_d   = 1'b1;
          2'b10:   snd_latch_d = cpu_dout;
          default: ;
        endcase
      end
    end

    case (A[2:0])
      3'b000:  port_in_d = {3'b111, start_button, service, coin_input};
      3'b001:  port_in_d = {2'b11, joystick1};
      3'b010:  port_in_d = {2'b11, joystick2};
      3'b100:  port_in_d = dipsw_a;
      3'b101:  port_in_d = dipsw_b;
      3'b110:  port_in_d = {4'b1111, dipsw_c};
      default: port_in_d = port_in_q;
    endcase

    if (irq_ack)                    irq_d = 1'b0;
    else if (~gfx_irqn & ~vrq_prev_q) irq_d = 1'b1;
  end

  // Resettable state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q      <= '0;
      snd_irq_q   <= 1'b0;
      snd_latch_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      snd_irq_q   <= snd_irq_d;
      snd_latch_q <= snd_latch_d;
      irq_q       <= irq_d;
    end
  end

  // Free-running samplers: edge history tracks through reset to avoid a spurious IRQ
  always_ff @(posedge clk) begin
    port_in_q  <= port_in_d;
    vrq_prev_q <= ~gfx_irqn;
  end

  assign irq_n     = ~irq_q;
  assign snd_irq   = snd_irq_q;
  assign snd_latch = snd_latch_q;
  assign cpu_addr  = A[12:0];
  assign cpu_rnw   = RnW;

endmodule

// File: tb/tb_contra_main_bus.sv
// Scoreboard bench for contra_main_bus: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_contra_main_bus;

  logic        clk = 1'b0;
  logic        rst, cpu_cen, RnW, irq_ack, gfx_irqn, service;
  logic [15:0] A;
  logic [7:0]  cpu_dout, cpu_din, ram_dout, rom_data, gfx1_dout, gfx2_dout, pal_dout;
  logic [7:0]  snd_latch, dipsw_a, dipsw_b;
  logic [16:0] rom_addr;
  logic [12:0] cpu_addr;
  logic        irq_n, ram_cs, rom_cs, cpu_rnw, gfx1_cs, gfx2_cs, gfx1_cfg_cs, gfx2_cfg_cs, pal_cs, snd_irq;
  logic [1:0]  start_button, coin_input;
  logic [5:0]  joystick1, joystick2;
  logic [3:0]  dipsw_c;

  contra_main_bus dut (
    .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .A(A), .RnW(RnW), .cpu_dout(cpu_dout),
    .cpu_din(cpu_din), .irq_ack(irq_ack), .irq_n(irq_n), .ram_cs(ram_cs), .rom_cs(rom_cs),
    .ram_dout(ram_dout), .rom_addr(rom_addr), .rom_data(rom_data), .cpu_addr(cpu_addr),
    .cpu_rnw(cpu_rnw), .gfx_irqn(gfx_irqn), .gfx1_cs(gfx1_cs), .gfx2_cs(gfx2_cs),
    .gfx1_cfg_cs(gfx1_cfg_cs), .gfx2_cfg_cs(gfx2_cfg_cs), .pal_cs(pal_cs),
    .gfx1_dout(gfx1_dout), .gfx2_dout(gfx2_dout), .pal_dout(pal_dout), .snd_irq(snd_irq),
    .snd_latch(snd_latch), .start_button(start_button), .coin_input(coin_input),
    .joystick1(joystick1), .joystick2(joystick2), .service(service),
    .dipsw_a(dipsw_a), .dipsw_b(dipsw_b), .dipsw_c(dipsw_c)
  );

  always #5 clk = ~clk;

  typedef enum int {S_DIN, S_ROMA, S_IRQN, S_SIRQ, S_LATCH, S_ROMCS, S_RAMCS} sig_e;
  typedef struct {
    sig_e        sel;
    logic [16:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   passed = 0;
  int   total  = 0;

  function automatic void expect_val(sig_e sel, logic [16:0] v, string nm);
    exp_t e;
    e.sel = sel; e.exp = v; e.name = nm;
    sb_q.push_back(e);
  endfunction

  function automatic logic [16:0] observe(sig_e sel);
    case (sel)
      S_DIN:   return 17'(cpu_din);
      S_ROMA:  return rom_addr;
      S_IRQN:  return 17'(irq_n);
      S_SIRQ:  return 17'(snd_irq);
      S_LATCH: return 17'(snd_latch);
      S_ROMCS: return 17'(rom_cs);
      default: return 17'(ram_cs);
    endcase
  endfunction

  // Monitor: compare every pending expectation away from the active edge
  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [16:0] act;
      e   = sb_q.pop_front();
      act = observe(e.sel);
      total++;
      if (act === e.exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data, input logic cen);
    A = addr; RnW = 1'b0; cpu_dout = data; cpu_cen = cen;
    tick();
    cpu_cen = 1'b0; RnW = 1'b1;
  endtask

  initial begin
    rst = 1'b1; cpu_cen = 1'b0; A = 16'h0000; RnW = 1'b1; cpu_dout = 8'h00;
    irq_ack = 1'b0; gfx_irqn = 1'b0; service = 1'b1;
    ram_dout = 8'h33; rom_data = 8'hA7; gfx1_dout = 8'h55; gfx2_dout = 8'h66; pal_dout = 8'h44;
    start_button = 2'b01; coin_input = 2'b10; joystick1 = 6'h15; joystick2 = 6'h2A;
    dipsw_a = 8'h81; dipsw_b = 8'h42; dipsw_c = 4'h3;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state; gfx_irqn held low through reset must not raise an IRQ
    A = 16'h6000;
    expect_val(S_IRQN, 17'h1, "reset_irq_n");
    expect_val(S_SIRQ, 17'h0, "reset_snd_irq");
    expect_val(S_LATCH, 17'h0, "reset_snd_latch");
    expect_val(S_ROMA, 17'h08000, "reset_rom_addr");
    expect_val(S_ROMCS, 17'h1, "reset_rom_cs");
    settle();
    gfx_irqn = 1'b1;
    tick();

    // ROM banking
    cpu_write(16'h7000, 8'h05, 1'b1);
    A = 16'h6123;
    expect_val(S_ROMA, 17'h12123, "bank5_rom_addr");
    settle();
    tick();
    cpu_write(16'h7000, 8'h03, 1'b0);
    A = 16'h6123;
    expect_val(S_ROMA, 17'h12123, "bank_write_no_cen");
    settle();
    tick();
    cpu_write(16'h7000, 8'h0C, 1'b1);
    A = 16'h6000;
    expect_val(S_ROMA, 17'h00000, "bank12_wrap");
    settle();
    tick();
    A = 16'h8001;
    expect_val(S_ROMA, 17'h00001, "fixed_rom_addr");
    expect_val(S_DIN, 17'hA7, "rom_read_data");
    settle();
    tick();

    // Sound latch and IRQ pulse
    cpu_write(16'h001C, 8'h5A, 1'b1);
    expect_val(S_LATCH, 17'h5A, "snd_latch_write");
    settle();
    tick();
    cpu_write(16'h001A, 8'h00, 1'b1);
    A = 16'h8000;
    expect_val(S_SIRQ, 17'h1, "snd_irq_set");
    settle();
    repeat (6) tick();
    expect_val(S_SIRQ, 17'h1, "snd_irq_holds");
    settle();
    tick();
    cpu_cen = 1'b1;
    tick();
    cpu_cen = 1'b0;
    expect_val(S_SIRQ, 17'h0, "snd_irq_cleared");
    settle();
    tick();
    cpu_write(16'h0018, 8'h77, 1'b1);
    expect_val(S_LATCH, 17'h5A, "coin_write_latch");
    expect_val(S_SIRQ, 17'h0, "coin_write_irq");
    settle();
    tick();

    // Input ports (registered, visible one clk after A)
    A = 16'h0001;
    tick();
    expect_val(S_DIN, 17'hD5, "port_joy1");
    settle();
    tick();
    A = 16'h0006;
    tick();
    expect_val(S_DIN, 17'hF3, "port_dipc");
    settle();
    tick();
    A = 16'h0003;
    tick();
    expect_val(S_DIN, 17'hF3, "port_hold");
    settle();
    tick();
    A = 16'h0000;
    tick();
    expect_val(S_DIN, 17'hEE, "port_system");
    settle();
    tick();
    A = 16'h0005;
    tick();
    expect_val(S_DIN, 17'h42, "port_dipb");
    settle();
    tick();

    // Read mux
    A = 16'h1000;
    expect_val(S_DIN, 17'h33, "mux_ram");
    expect_val(S_RAMCS, 17'h1, "ram_cs");
    settle();
    tick();
    A = 16'h0C00;
    expect_val(S_DIN, 17'h44, "mux_pal");
    settle();
    tick();
    A = 16'h2000;
    expect_val(S_DIN, 17'h55, "mux_gfx1");
    settle();
    tick();
    A = 16'h4000;
    expect_val(S_DIN, 17'h66, "mux_gfx2");
    settle();
    tick();
    A = 16'h6000; RnW = 1'b0;
    expect_val(S_DIN, 17'hFF, "mux_open_bus");
    expect_val(S_ROMCS, 17'h0, "rom_cs_write");
    settle();
    tick();
    RnW = 1'b1;

    // Video IRQ edge, ack, no re-trigger while held low
    gfx_irqn = 1'b0;
    expect_val(S_IRQN, 17'h1, "irq_before_edge");
    settle();
    tick();
    expect_val(S_IRQN, 17'h0, "irq_set");
    settle();
    tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    expect_val(S_IRQN, 17'h1, "irq_acked");
    settle();
    repeat (3) tick();
    expect_val(S_IRQN, 17'h1, "irq_no_retrigger");
    settle();
    tick();
    gfx_irqn = 1'b1;
    tick();
    gfx_irqn = 1'b0; irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    expect_val(S_IRQN, 17'h1, "irq_ack_priority");
    settle();
    repeat (2) tick();
    expect_val(S_IRQN, 17'h1, "irq_ack_priority_hold");
    settle();
    tick();

    // Reset overrides a cen write
    rst = 1'b1;
    cpu_write(16'h001C, 8'h99, 1'b1);
    expect_val(S_LATCH, 17'h0, "rst_over_cen");
    settle();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) tick();
    if (sb_q.size() > 0) begin
      total++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
